// File: rtl/cpu_mem_pkg.sv
// Shared CPU/memory definitions: address field widths, block width and cache FSM states.
// Also used by the data memory model, which works in whole blocks.
package cpu_mem_pkg;
  localparam int ADDR_W      = 8;
  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int IDX_W       = $clog2(NUM_BLOCKS);
  localparam int OFF_W       = $clog2(BLOCK_BYTES);
  localparam int TAG_W       = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W       = 8 * BLOCK_BYTES;
  localparam int MADDR_W     = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WRITE_BACK = 2'd1,
    S_ALLOCATE   = 2'd2,
    S_UPDATE     = 2'd3
  } cache_state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction
endpackage

// File: rtl/cache_line_array.sv
// Line storage: valid/dirty/tag/data with a combinational read port and a
// synchronous write port that either stores one byte or fills a whole block.
module cache_line_array #(
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_BYTES = 4,
  parameter int TAG_W       = 3
) (
  input  logic                                CLK,
  input  logic                                RESET,
  input  logic [$clog2(NUM_BLOCKS)-1:0]       i_idx,
  input  logic [$clog2(BLOCK_BYTES)-1:0]      i_off,
  output logic                                o_valid,
  output logic                                o_dirty,
  output logic [TAG_W-1:0]                    o_tag,
  output logic [8*BLOCK_BYTES-1:0]            o_data,
  input  logic                                i_byte_we,
  input  logic [7:0]                          i_byte,
  input  logic                                i_fill_we,
  input  logic [TAG_W-1:0]                    i_fill_tag,
  input  logic [8*BLOCK_BYTES-1:0]            i_fill_data
);
  logic [NUM_BLOCKS-1:0]                   r_valid;
  logic [NUM_BLOCKS-1:0]                   r_dirty;
  logic [NUM_BLOCKS-1:0][TAG_W-1:0]        r_tag;
  logic [NUM_BLOCKS-1:0][BLOCK_BYTES-1:0][7:0] r_data;

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

  // Only the status bits reset; tag and data contents are don't-care until valid.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_byte_we) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (i_fill_we) begin
      r_tag[i_idx]  <= i_fill_tag;
      r_data[i_idx] <= i_fill_data;
    end else if (i_byte_we) begin
      r_data[i_idx][i_off] <= i_byte;
    end
  end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back data cache. Hits finish with no stall; misses write
// back a dirty victim, refill the block from memory, then replay as a hit.
module data_cache #(
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_BYTES = 4,
  parameter int ADDR_W      = 8
) (
  input  logic                                         CLK,
  input  logic                                         RESET,
  input  logic                                         READ,
  input  logic                                         WRITE,
  input  logic [ADDR_W-1:0]                            ADDRESS,
  input  logic [7:0]                                   WRITEDATA,
  output logic [7:0]                                   READDATA,
  output logic                                         BUSYWAIT,
  output logic                                         MEM_READ,
  output logic                                         MEM_WRITE,
  output logic [ADDR_W-$clog2(BLOCK_BYTES)-1:0]        MEM_ADDRESS,
  output logic [8*BLOCK_BYTES-1:0]                     MEM_WRITEDATA,
  input  logic [8*BLOCK_BYTES-1:0]                     MEM_READDATA,
  input  logic                                         MEM_BUSYWAIT
);
  import cpu_mem_pkg::*;

  localparam int C_IDX_W = $clog2(NUM_BLOCKS);
  localparam int C_OFF_W = $clog2(BLOCK_BYTES);
  localparam int C_TAG_W = ADDR_W - C_IDX_W - C_OFF_W;
  localparam int C_BLK_W = 8 * BLOCK_BYTES;

  logic [C_TAG_W-1:0]               w_tag;
  logic [C_TAG_W-1:0]               w_line_tag;
  logic [C_IDX_W-1:0]               w_idx;
  logic [C_OFF_W-1:0]               w_off;
  logic                             w_valid;
  logic                             w_dirty;
  logic                             w_hit;
  logic                             w_req;
  logic                             w_byte_we;
  logic                             w_fill_we;
  logic [C_BLK_W-1:0]               w_line_data;
  logic [BLOCK_BYTES-1:0][7:0]      w_line_bytes;
  cache_state_t                     r_state;
  logic [C_BLK_W-1:0]               r_fill;

  assign w_tag        = ADDRESS[ADDR_W-1 -: C_TAG_W];
  assign w_idx        = ADDRESS[C_OFF_W +: C_IDX_W];
  assign w_off        = ADDRESS[C_OFF_W-1:0];
  assign w_line_bytes = w_line_data;
  assign w_hit        = w_valid && (w_line_tag == w_tag);
  assign w_req        = READ || WRITE;
  assign w_byte_we    = (r_state == S_IDLE) && WRITE && w_hit;
  assign w_fill_we    = (r_state == S_UPDATE);

  cache_line_array #(
    .NUM_BLOCKS  (NUM_BLOCKS),
    .BLOCK_BYTES (BLOCK_BYTES),
    .TAG_W       (C_TAG_W)
  ) u_lines (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_idx       (w_idx),
    .i_off       (w_off),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_line_tag),
    .o_data      (w_line_data),
    .i_byte_we   (w_byte_we),
    .i_byte      (WRITEDATA),
    .i_fill_we   (w_fill_we),
    .i_fill_tag  (w_tag),
    .i_fill_data (r_fill)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:       if (w_req && !w_hit) r_state <= (w_valid && w_dirty) ? S_WRITE_BACK : S_ALLOCATE;
        S_WRITE_BACK: if (!MEM_BUSYWAIT) r_state <= S_ALLOCATE;
        S_ALLOCATE:   if (!MEM_BUSYWAIT) r_state <= S_UPDATE;
        S_UPDATE:     r_state <= S_IDLE;
        default:      r_state <= S_IDLE;
      endcase
    end
  end

  // Refill block is held one cycle so UPDATE commits it independently of memory.
  always_ff @(posedge CLK) begin
    if (r_state == S_ALLOCATE && !MEM_BUSYWAIT) r_fill <= MEM_READDATA;
  end

  // Stall is combinational so a miss freezes the CPU in the cycle it is presented.
  always_comb begin
    BUSYWAIT      = (r_state != S_IDLE) || (w_req && !w_hit);
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    READDATA      = '0;
    case (r_state)
      S_IDLE:       if (READ && !WRITE && w_hit) READDATA = w_line_bytes[w_off];
      S_WRITE_BACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {w_line_tag, w_idx};
        MEM_WRITEDATA = w_line_data;
      end
      S_ALLOCATE: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {w_tag, w_idx};
      end
      default: ;
    endcase
  end

  a_rw_exclusive: assert property (@(posedge CLK) disable iff (RESET) !(READ && WRITE));
  a_req_stable: assert property (@(posedge CLK) disable iff (RESET)
    (r_state != S_IDLE) |-> ($stable(ADDRESS) && $stable(READ) && $stable(WRITE)));
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed miss/hit/write-back/reset-abort
// scenarios, then a random load/store stream against a flat byte-array model.
module tb_data_cache;
  logic        CLK, RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [64];
  logic [7:0]  ref_b [256];
  int          mem_lat = 5;
  bit          rand_lat = 0;

  data_cache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Block memory: busy from the first request cycle, low in the cycle number equal to the latency.
  initial begin : mem_model
    bit act;
    int cnt, cur_lat;
    act = 0; cnt = 0; cur_lat = 1;
    MEM_BUSYWAIT = 1'b0;
    MEM_READDATA = '0;
    forever begin
      @(posedge CLK); #3;
      if (MEM_READ || MEM_WRITE) begin
        if (!act) begin
          act = 1; cnt = 0;
          cur_lat = rand_lat ? int'($urandom_range(1, 10)) : mem_lat;
        end
        cnt++;
        if (cnt >= cur_lat) begin
          if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
          else           MEM_READDATA = mem[MEM_ADDRESS];
          MEM_BUSYWAIT = 1'b0;
          act = 0;
        end else begin
          MEM_BUSYWAIT = 1'b1;
        end
      end else begin
        act = 0;
        MEM_BUSYWAIT = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  // Presents one request at +1 after an edge, holds it until BUSYWAIT drops, returns at +1.
  task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        output logic [7:0] rd, output int cyc);
    READ = !wr; WRITE = wr; ADDRESS = a; WRITEDATA = wd; cyc = 0;
    #1;
    while (BUSYWAIT !== 1'b0 && cyc < 400) begin
      @(posedge CLK); #2; cyc++;
    end
    checks++;
    if (BUSYWAIT !== 1'b0) begin
      errors++;
      $display("FAIL access_timeout addr=%h busywait=%b after %0d cycles, required 0", a, BUSYWAIT, cyc);
    end
    rd = READDATA;
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    repeat (2) @(posedge CLK);
    #2;
    checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busywait got %b want 0", BUSYWAIT); end
    checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b want 0", MEM_READ); end
    checks++; if (MEM_WRITE !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b want 0", MEM_WRITE); end
    checks++; if (MEM_ADDRESS !== 6'h0) begin errors++; $display("FAIL reset_mem_address got %h want 00", MEM_ADDRESS); end
    checks++; if (MEM_WRITEDATA !== 32'h0) begin errors++; $display("FAIL reset_mem_writedata got %h want 0", MEM_WRITEDATA); end
    checks++; if (READDATA !== 8'h0) begin errors++; $display("FAIL reset_readdata got %h want 00", READDATA); end
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic test_first_miss();
    int cyc;
    mem_lat = 5;
    READ = 1'b1; ADDRESS = 8'h05;
    #1;
    checks++; if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL miss_busy_same_cycle got %b want 1", BUSYWAIT); end
    @(posedge CLK); #2; cyc = 1;
    checks++; if (MEM_READ !== 1'b1) begin errors++; $display("FAIL miss_mem_read got %b want 1", MEM_READ); end
    checks++; if (MEM_ADDRESS !== 6'h01) begin errors++; $display("FAIL miss_mem_address got %h want 01", MEM_ADDRESS); end
    while (BUSYWAIT !== 1'b0 && cyc < 50) begin @(posedge CLK); #2; cyc++; end
    checks++; if (cyc != 7) begin errors++; $display("FAIL miss_stall_cycles got %0d want 7", cyc); end
    checks++; if (READDATA !== 8'h22) begin errors++; $display("FAIL miss_readdata got %h want 22", READDATA); end
    @(posedge CLK); #1;
    READ = 1'b0;
  endtask

  task automatic test_read_hits();
    logic [7:0] rd; int cyc;
    access(0, 8'h05, 8'h00, rd, cyc);
    checks++; if (cyc != 0) begin errors++; $display("FAIL hit05_stall got %0d want 0", cyc); end
    checks++; if (rd !== 8'h22) begin errors++; $display("FAIL hit05_data got %h want 22", rd); end
    access(0, 8'h07, 8'h00, rd, cyc);
    checks++; if (cyc != 0) begin errors++; $display("FAIL hit07_stall got %0d want 0", cyc); end
    checks++; if (rd !== 8'h44) begin errors++; $display("FAIL hit07_data got %h want 44", rd); end
  endtask

  task automatic test_write_hit();
    logic [7:0] rd; int cyc;
    access(1, 8'h06, 8'hAB, rd, cyc);
    checks++; if (cyc != 0) begin errors++; $display("FAIL write_hit_stall got %0d want 0", cyc); end
    access(0, 8'h06, 8'h00, rd, cyc);
    checks++; if (cyc != 0) begin errors++; $display("FAIL write_hit_read_stall got %0d want 0", cyc); end
    checks++; if (rd !== 8'hAB) begin errors++; $display("FAIL write_hit_read_data got %h want ab", rd); end
  endtask

  task automatic test_dirty_miss();
    int cyc;
    mem_lat = 3;
    READ = 1'b1; ADDRESS = 8'h25;
    #1;
    checks++; if (BUSYWAIT !== 1'b1) begin errors++; $display("FAIL dirty_busy_same_cycle got %b want 1", BUSYWAIT); end
    @(posedge CLK); #2; cyc = 1;
    checks++; if (MEM_WRITE !== 1'b1 || MEM_READ !== 1'b0) begin errors++; $display("FAIL wb_strobes got wr=%b rd=%b want wr=1 rd=0", MEM_WRITE, MEM_READ); end
    checks++; if (MEM_ADDRESS !== 6'h01) begin errors++; $display("FAIL wb_address got %h want 01", MEM_ADDRESS); end
    checks++; if (MEM_WRITEDATA !== 32'h44AB2211) begin errors++; $display("FAIL wb_data got %h want 44ab2211", MEM_WRITEDATA); end
    while (MEM_READ !== 1'b1 && cyc < 50) begin @(posedge CLK); #2; cyc++; end
    checks++; if (cyc != 4) begin errors++; $display("FAIL alloc_start_cycle got %0d want 4", cyc); end
    checks++; if (MEM_ADDRESS !== 6'h09) begin errors++; $display("FAIL alloc_address got %h want 09", MEM_ADDRESS); end
    while (BUSYWAIT !== 1'b0 && cyc < 100) begin @(posedge CLK); #2; cyc++; end
    checks++; if (cyc != 8) begin errors++; $display("FAIL dirty_stall_cycles got %0d want 8", cyc); end
    checks++; if (READDATA !== 8'h66) begin errors++; $display("FAIL dirty_readdata got %h want 66", READDATA); end
    checks++; if (mem[1] !== 32'h44AB2211) begin errors++; $display("FAIL wb_memory got %h want 44ab2211", mem[1]); end
    @(posedge CLK); #1;
    READ = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [7:0] rd; int cyc;
    mem_lat = 10;
    READ = 1'b1; ADDRESS = 8'h45;
    tick(); tick();
    RESET = 1'b1; READ = 1'b0;
    tick();
    RESET = 1'b0;
    #1;
    checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL abort_mem_read got %b want 0", MEM_READ); end
    checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL abort_busywait got %b want 0", BUSYWAIT); end
    tick();
    mem_lat = 2;
    access(0, 8'h05, 8'h00, rd, cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL abort_remiss_stall got %0d want 4", cyc); end
    checks++; if (rd !== 8'h22) begin errors++; $display("FAIL abort_remiss_data got %h want 22", rd); end
  endtask

  task automatic test_random_stream();
    logic [7:0] rd, a, d, blk_addr;
    logic [31:0] exp;
    int cyc;
    // Start from invalidated lines so memory alone holds the true contents.
    RESET = 1'b1; tick(); RESET = 1'b0;
    for (int i = 0; i < 256; i++) ref_b[i] = mem[i / 4][8 * (i % 4) +: 8];
    rand_lat = 1;
    for (int n = 0; n < 300; n++) begin
      a = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        access(1, a, d, rd, cyc);
        ref_b[a] = d;
      end else begin
        access(0, a, 8'h00, rd, cyc);
        checks++;
        if (rd !== ref_b[a]) begin errors++; $display("FAIL rand_load addr=%h got %h want %h", a, rd, ref_b[a]); end
      end
    end
    // Two reads per index with distinct tags force every dirty line out to memory.
    for (int i = 0; i < 8; i++) begin
      access(0, {3'd6, 3'(i), 2'd0}, 8'h00, rd, cyc);
      access(0, {3'd7, 3'(i), 2'd0}, 8'h00, rd, cyc);
    end
    rand_lat = 0;
    for (int b = 0; b < 64; b++) begin
      for (int k = 0; k < 4; k++) exp[8 * k +: 8] = ref_b[b * 4 + k];
      blk_addr = 8'(b);
      checks++;
      if (mem[b] !== exp) begin errors++; $display("FAIL flush_block %h got %h want %h", blk_addr, mem[b], exp); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[1] = 32'h44332211;
    mem[9] = 32'h88776655;
    test_reset();
    test_first_miss();
    test_read_hits();
    test_write_hit();
    test_dirty_miss();
    test_reset_abort();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
